stack_sequencer: RTL

//  Program sequencer for the signed stack ALU (push/pop/add/mul, opcodes 110/111/100/101).

---
 rtl/stack_sequencer_pkg.sv | 24 ++
 rtl/seq_prog_mem.sv | 24 ++
 rtl/stack_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_pkg.sv
// Shared opcodes, error codes and FSM state encoding for the stack program sequencer.
package stack_sequencer_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_FULL  = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Instruction store: register array with a synchronous write port and an asynchronous read port.
module seq_prog_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_sequencer.sv
// Runs a host-loaded program against the stack ALU, one op per ISSUE/CHECK pair,
// guarding stack depth itself and reporting done/error/pc/result.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int PROG_DEPTH  = 32,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [DATA_WIDTH+2:0]         prog_wdata,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic [DATA_WIDTH-1:0]         result,
    output logic [2:0]                    stk_opcode,
    output logic [DATA_WIDTH-1:0]         stk_data_in,
    input  logic [DATA_WIDTH-1:0]         stk_data_out,
    input  logic                          stk_empty,
    input  logic                          stk_full,
    input  logic                          stk_overflow
);

    localparam int AW      = $clog2(PROG_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    state_t               state;
    logic [DEPTH_W-1:0]   depth;
    logic [2:0]           cur_op;
    logic [DATA_WIDTH+2:0] instr;
    logic [2:0]           op;
    logic [DATA_WIDTH-1:0] imm;
    logic                 is_exec;
    logic                 err_full;
    logic                 err_under;
    logic                 fire;
    logic                 unused_flags;

    // Status flags from the stack are only cross-checked outside this block.
    assign unused_flags = stk_empty ^ stk_full;

    seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .WIDTH (DATA_WIDTH + 3)
    ) u_prog_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (instr)
    );

    assign op  = instr[DATA_WIDTH+2:DATA_WIDTH];
    assign imm = instr[DATA_WIDTH-1:0];

    always_comb begin
        is_exec   = (op == OP_PUSH) || (op == OP_POP) || (op == OP_ADD) || (op == OP_MUL);
        err_full  = (op == OP_PUSH) && (depth == DEPTH_W'(STACK_DEPTH));
        err_under = ((op == OP_POP) && (depth == '0)) ||
                    (((op == OP_ADD) || (op == OP_MUL)) && (depth < DEPTH_W'(2)));
        fire      = (state == ST_ISSUE) && is_exec && !err_full && !err_under;
    end

    // The stack samples its opcode on the edge that ends ISSUE, so the drive must be
    // combinational from the current instruction rather than a registered copy.
    assign stk_opcode  = fire ? op : OP_NOP;
    assign stk_data_in = fire ? imm : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            pc       <= '0;
            result   <= '0;
            depth    <= '0;
            cur_op   <= OP_NOP;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state    <= ST_ISSUE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        pc       <= '0;
                        depth    <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (op == OP_HALT) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (err_full || err_under) begin
                        state    <= ST_ERROR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= err_full ? ERR_FULL : ERR_UNDER;
                    end else begin
                        state  <= ST_CHECK;
                        cur_op <= op;
                        if (op == OP_PUSH) begin
                            depth <= depth + DEPTH_W'(1);
                        end else if (is_exec) begin
                            depth <= depth - DEPTH_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    result <= stk_data_out;
                    if (((cur_op == OP_ADD) || (cur_op == OP_MUL)) && stk_overflow && STOP_ON_OVF) begin
                        state    <= ST_ERROR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_OVF;
                    end else if (pc == AW'(PROG_DEPTH - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_ISSUE;
                        pc    <= pc + AW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
